// File: rtl/cpu_types_pkg.sv
// rtl/cpu_types_pkg.sv - shared CPU datapath types and constants
package cpu_types_pkg;

    localparam int XLEN        = 32;
    localparam int SHIFT_AMT_W = 8;

    typedef enum logic [1:0] {
        SHIFT_LSL = 2'b00,
        SHIFT_LSR = 2'b01,
        SHIFT_ASR = 2'b10,
        SHIFT_ROR = 2'b11
    } shift_type_t;

    typedef struct packed {
        logic [XLEN-1:0] word;
        logic            carry;
    } shift_result_t;

endpackage

// File: rtl/shift_core.sv
// rtl/shift_core.sv - combinational barrel shift and shifter carry function
module shift_core
    import cpu_types_pkg::*;
#(
    parameter int WIDTH = 32,
    parameter int AMT_W = SHIFT_AMT_W
) (
    input  logic [WIDTH-1:0] r_in,
    input  logic [AMT_W-1:0] amt,
    input  logic             imm_mode,
    input  shift_type_t      shift_type,
    input  logic             carry_in,
    output logic [WIDTH-1:0] word,
    output logic             carry
);

    localparam int SH_W = $clog2(WIDTH);

    logic [SH_W-1:0]  sh;
    logic [SH_W-1:0]  sh_m1;
    logic [SH_W-1:0]  sh_neg;
    logic [31:0]      amt_ext;
    logic             amt_zero;
    logic             amt_lt;
    logic             amt_eq;
    logic             sign;
    logic [WIDTH-1:0] lsl_w;
    logic [WIDTH-1:0] lsr_w;
    logic [WIDTH-1:0] asr_w;
    logic [WIDTH-1:0] ror_w;

    // Range tests use the full amount; only the in-range path uses the low bits.
    assign amt_ext  = 32'(amt);
    assign amt_zero = (amt_ext == 32'd0);
    assign amt_lt   = (amt_ext < WIDTH);
    assign amt_eq   = (amt_ext == WIDTH);

    assign sh     = amt[SH_W-1:0];
    assign sh_m1  = sh - SH_W'(1);
    assign sh_neg = SH_W'(0) - sh;
    assign sign   = r_in[WIDTH-1];

    assign lsl_w = r_in << sh;
    assign lsr_w = r_in >> sh;
    assign asr_w = $signed(r_in) >>> sh;
    assign ror_w = (r_in >> sh) | (r_in << (WIDTH - int'(sh)));

    always_comb begin
        word  = r_in;
        carry = carry_in;
        if (imm_mode && amt_zero) begin
            unique case (shift_type)
                SHIFT_LSL: begin
                    word  = r_in;
                    carry = carry_in;
                end
                SHIFT_LSR: begin
                    word  = '0;
                    carry = sign;
                end
                SHIFT_ASR: begin
                    word  = {WIDTH{sign}};
                    carry = sign;
                end
                SHIFT_ROR: begin
                    word  = {carry_in, r_in[WIDTH-1:1]};
                    carry = r_in[0];
                end
            endcase
        end else if (!amt_zero) begin
            unique case (shift_type)
                SHIFT_LSL: begin
                    if (amt_lt) begin
                        word  = lsl_w;
                        carry = r_in[sh_neg];
                    end else begin
                        word  = '0;
                        carry = amt_eq ? r_in[0] : 1'b0;
                    end
                end
                SHIFT_LSR: begin
                    if (amt_lt) begin
                        word  = lsr_w;
                        carry = r_in[sh_m1];
                    end else begin
                        word  = '0;
                        carry = amt_eq ? sign : 1'b0;
                    end
                end
                SHIFT_ASR: begin
                    if (amt_lt) begin
                        word  = asr_w;
                        carry = r_in[sh_m1];
                    end else begin
                        word  = {WIDTH{sign}};
                        carry = sign;
                    end
                end
                SHIFT_ROR: begin
                    if (sh == '0) begin
                        word  = r_in;
                        carry = sign;
                    end else begin
                        word  = ror_w;
                        carry = r_in[sh_m1];
                    end
                end
            endcase
        end
    end

endmodule

// File: rtl/shifter_pipe.sv
// rtl/shifter_pipe.sv - shifter with amount latch and valid/ready output pipeline
module shifter_pipe
    import cpu_types_pkg::*;
#(
    parameter int WIDTH  = 32,
    parameter int AMT_W  = SHIFT_AMT_W,
    parameter int STAGES = 1
) (
    input  logic                     clk,
    input  logic                     rst_n,
    input  logic                     in_valid,
    output logic                     in_ready,
    input  logic [WIDTH-1:0]         r_in,
    input  logic [WIDTH-1:0]         rs_in,
    input  logic [$clog2(WIDTH)-1:0] imm_amt,
    input  logic                     imm_mode,
    input  shift_type_t              shift_type,
    input  logic                     carry_in,
    input  logic                     latch_amt,
    input  logic                     use_amt_latch,
    output logic [WIDTH-1:0]         op_b,
    output logic                     carry_out,
    output logic                     out_valid,
    input  logic                     out_ready
);

    logic [AMT_W-1:0] amt_q;
    logic [AMT_W-1:0] amt_eff;
    logic [WIDTH-1:0] core_word;
    logic             core_carry;
    logic             accept;
    logic             s1_valid;
    logic [WIDTH-1:0] s1_word;
    logic             s1_carry;
    logic             s1_ready;
    logic             unused_rs_hi;

    assign unused_rs_hi = ^rs_in[WIDTH-1:AMT_W];

    // A same-cycle latch+use reads the pre-edge value of amt_q.
    always_ff @(posedge clk or negedge rst_n) begin
        if (!rst_n) begin
            amt_q <= '0;
        end else if (latch_amt) begin
            amt_q <= rs_in[AMT_W-1:0];
        end
    end

    always_comb begin
        amt_eff = rs_in[AMT_W-1:0];
        if (imm_mode) begin
            amt_eff = AMT_W'(imm_amt);
        end else if (use_amt_latch) begin
            amt_eff = amt_q;
        end
    end

    shift_core #(
        .WIDTH (WIDTH),
        .AMT_W (AMT_W)
    ) u_core (
        .r_in       (r_in),
        .amt        (amt_eff),
        .imm_mode   (imm_mode),
        .shift_type (shift_type),
        .carry_in   (carry_in),
        .word       (core_word),
        .carry      (core_carry)
    );

    assign in_ready = s1_ready;
    assign accept   = in_valid && s1_ready;

    always_ff @(posedge clk or negedge rst_n) begin
        if (!rst_n) begin
            s1_valid <= 1'b0;
            s1_word  <= '0;
            s1_carry <= 1'b0;
        end else begin
            if (s1_ready) begin
                s1_valid <= in_valid;
            end
            if (accept) begin
                s1_word  <= core_word;
                s1_carry <= core_carry;
            end
        end
    end

    generate
        if (STAGES == 1) begin : g_one_stage
            assign s1_ready  = !s1_valid || out_ready;
            assign out_valid = s1_valid;
            assign op_b      = s1_word;
            assign carry_out = s1_carry;
        end else begin : g_two_stage
            logic             s2_valid;
            logic [WIDTH-1:0] s2_word;
            logic             s2_carry;
            logic             s2_ready;

            assign s2_ready  = !s2_valid || out_ready;
            assign s1_ready  = !s1_valid || s2_ready;
            assign out_valid = s2_valid;
            assign op_b      = s2_word;
            assign carry_out = s2_carry;

            always_ff @(posedge clk or negedge rst_n) begin
                if (!rst_n) begin
                    s2_valid <= 1'b0;
                    s2_word  <= '0;
                    s2_carry <= 1'b0;
                end else if (s2_ready) begin
                    s2_valid <= s1_valid;
                    if (s1_valid) begin
                        s2_word  <= s1_word;
                        s2_carry <= s1_carry;
                    end
                end
            end
        end
    endgenerate

endmodule
